shiyan9_dff: RTL and testbench
==============================

Name: shiyan9_dff

Overview:
- Single-bit positive-edge D flip-flop with asynchronous active-low preset and asynchronous active-low clear, plus true and complementary outputs.
- It is the 74LS74-style storage primitive used by the lab designs.
- It sits as a leaf cell wherever a settable and resettable state bit is needed.
- Implementation is a small behavioural register plus an output-forcing stage for the both-asserted case.

Parameters:
- None. Width is fixed at 1 bit.

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  reset. Asynchronous, active-low. Clears the stored bit.
- pre  input  1  asynchronous active-low preset. Sets the stored bit.
- d    input  1  data input, sampled on the rising edge of clk.
- q    output 1  true output.
- qb   output 1  complementary output.

Interface (already decided): one clock (clk); reset is asynchronous and active-low (clr).

Behaviour:
- Internal state bit s. Outputs are purely a function of s, pre and clr. There is no output register beyond s.
- Priority, highest first:
  1. clr=0 and pre=0
  2. clr=0
  3. pre=0
  4. clock edge
- clr=0 and pre=1:
  - s becomes 0 immediately, without waiting for a clock.
  - q=0, qb=1.
  - Clock edges are ignored.
- pre=0 and clr=1:
  - s becomes 1 immediately.
  - q=1, qb=0.
  - Clock edges are ignored.
- pre=0 and clr=0 (both asserted, illegal-but-defined):
  - q=1 and qb=1, both forced high, as in the 74LS74.
  - s is held at 0, because clear has priority on the state.
  - Clock edges are ignored.
- Release from the both-asserted state:
  - If both deassert together, the outputs return to q=0, qb=1, because s=0.
  - If clr deasserts first, preset applies: q=1, qb=0.
  - If pre deasserts first, clear applies: q=0, qb=1.
- pre=1 and clr=1:
  - On each rising clk edge, s <= d.
  - q=s, qb=~s.
  - Zero cycles of latency after the edge, i.e. the output updates at the edge.
- Asynchronous assertion coincident with a clock rising edge: the asynchronous control wins and the edge is not captured.
- Deassertion of pre/clr coincident with a rising edge: the edge is captured normally. Not exercised by the bench, because the timing is undefined.
- Power-up: no reset value is guaranteed until clr or pre is asserted. The bench must apply clr=0 first.
- Outputs change only on:
  - an asynchronous control edge, or
  - a rising clk edge while both controls are deasserted.
- Level changes on d or clk without a rising edge do not change the outputs.

Test Plan:
1. Clear: pre=1, clr=0, d=1, clk=0 held for 100 ns -> q=0, qb=1.
2. Preset overrides the clock: pre=0, clr=1, clk rises with d=0 -> q=1, qb=0. The edge is ignored.
3. Hold: pre=1, clr=1, clk falls, d=1 -> q stays 1, qb stays 0. There is no capture on the falling edge.
4. Clocked capture: pre=1, clr=1, clk rises with d=0 -> q=0, qb=1. Then the next rising edge with d=1 -> q=1, qb=0.
5. Both asserted: pre=0, clr=0, with clk=0 then a rising clk and d=0 -> q=1, qb=1 throughout.
6. Release order:
   - From both-asserted, raise clr first -> q=1, qb=0.
   - From both-asserted, raise pre first -> q=0, qb=1.
   - From both-asserted, raise both together -> q=0, qb=1.
   - After any release, a rising edge with pre=1, clr=1, d=1 -> q=1, qb=0.

Source files
------------

// File: rtl/shiyan9_dff.sv
// shiyan9_dff: single-bit rising-edge D flip-flop with asynchronous
// active-low clear and preset, true and complementary outputs.
// Behaves like one half of a 74LS74, including both outputs high
// while clear and preset are asserted together.
module shiyan9_dff (
   input  logic clk,
   input  logic clr,
   input  logic pre,
   input  logic d,
   output logic q,
   output logic qb
);

   logic s;
   logic set_n;

   // Preset acts on the state only while clear is released. Releasing clr
   // while pre is still low therefore produces a falling edge on set_n,
   // and the preset takes hold of the state at that moment.
   assign set_n = pre | ~clr;

   // Stored bit: clear beats preset, and both beat the clock edge.
   always_ff @(posedge clk or negedge clr or negedge set_n) begin
      if (!clr) begin
         s <= 1'b0;
      end else if (!set_n) begin
         s <= 1'b1;
      end else begin
         s <= d;
      end
   end

   // Output forcing: an asserted preset drives q high and an asserted clear
   // drives qb high. With both asserted, both outputs are high.
   always_comb begin
      q  = ~pre | (clr & s);
      qb = ~clr | (pre & ~s);
   end

endmodule

// File: tb/tb_shiyan9_dff.sv
// Self-checking bench for shiyan9_dff: directed vector table, randomized
// stimulus against a rule-level reference model, and hand-written
// sequences for async control coincident with a clock edge.
module tb_shiyan9_dff;

   logic clk = 1'b0;
   logic clr = 1'b1;
   logic pre = 1'b1;
   logic d   = 1'b0;
   logic q;
   logic qb;

   int checks = 0;
   int passed = 0;

   localparam int NONE = 0;
   localparam int TOG  = 1;

   typedef struct {
      string name;
      logic  pre;
      logic  clr;
      logic  d;
      int    act;
      int    hold;
      logic  eq;
      logic  eqb;
   } vec_t;

   vec_t vecs[$];

   // Reference model state
   logic m_s;

   shiyan9_dff dut (
      .clk (clk),
      .clr (clr),
      .pre (pre),
      .d   (d),
      .q   (q),
      .qb  (qb)
   );

   task automatic check(input string name, input logic eq, input logic eqb);
      checks++;
      if (q === eq && qb === eqb) begin
         passed++;
      end else begin
         $display("FAIL %s: q/qb = %b%b, required %b%b", name, q, qb, eq, eqb);
      end
   endtask

   // Drive controls and data, wait, then optionally toggle the clock.
   task automatic drive(input logic p, input logic c, input logic dd,
                        input int act, input int hold);
      pre = p;
      clr = c;
      d   = dd;
      #(hold);
      if (act == TOG) begin
         clk = ~clk;
         #5;
      end
      #2;
   endtask

   // Model outputs from the documented rules.
   function automatic logic [1:0] model_out(input logic p, input logic c, input logic s_v);
      if (!p && !c) return 2'b11;
      if (!c)       return 2'b01;
      if (!p)       return 2'b10;
      return {s_v, ~s_v};
   endfunction

   function automatic vec_t mk(input string n, input logic p, input logic c,
                               input logic dd, input int act, input int hold,
                               input logic eq, input logic eqb);
      vec_t v;
      v.name = n; v.pre = p; v.clr = c; v.d = dd;
      v.act = act; v.hold = hold; v.eq = eq; v.eqb = eqb;
      return v;
   endfunction

   initial begin
      logic p, c, dd, tog;
      logic [1:0] mo;

      // Directed table; clk starts low and each TOG flips it.
      vecs.push_back(mk("clear_hold",       1, 0, 1, NONE, 100, 0, 1));
      vecs.push_back(mk("preset_rise",      0, 1, 0, TOG,  5,   1, 0));
      vecs.push_back(mk("hold_fall",        1, 1, 1, TOG,  5,   1, 0));
      vecs.push_back(mk("capture_d0",       1, 1, 0, TOG,  5,   0, 1));
      vecs.push_back(mk("fall_no_capture",  1, 1, 1, TOG,  5,   0, 1));
      vecs.push_back(mk("capture_d1",       1, 1, 1, TOG,  5,   1, 0));
      vecs.push_back(mk("both_clk_low",     0, 0, 1, TOG,  5,   1, 1));
      vecs.push_back(mk("both_rise",        0, 0, 0, TOG,  5,   1, 1));
      vecs.push_back(mk("rel_clr_first",    0, 1, 0, NONE, 5,   1, 0));
      vecs.push_back(mk("rel_clr_then_pre", 1, 1, 0, NONE, 5,   1, 0));
      vecs.push_back(mk("both_again",       0, 0, 0, TOG,  5,   1, 1));
      vecs.push_back(mk("rel_pre_first",    1, 0, 0, NONE, 5,   0, 1));
      vecs.push_back(mk("rel_pre_then_clr", 1, 1, 0, NONE, 5,   0, 1));
      vecs.push_back(mk("both_third",       0, 0, 0, NONE, 5,   1, 1));
      vecs.push_back(mk("rel_together",     1, 1, 1, NONE, 5,   0, 1));
      vecs.push_back(mk("rise_after_rel",   1, 1, 1, TOG,  5,   1, 0));
      vecs.push_back(mk("d_change_no_edge", 1, 1, 0, NONE, 5,   1, 0));

      // Settle inputs deasserted, then apply clear first.
      #1;
      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].pre, vecs[i].clr, vecs[i].d, vecs[i].act, vecs[i].hold);
         check(vecs[i].name, vecs[i].eq, vecs[i].eqb);
      end

      // Randomized phase against the rule model; state is known (s=1, clk high).
      m_s = 1'b1;
      for (int i = 0; i < 400; i++) begin
         p   = ($urandom_range(0, 3) != 0);
         c   = ($urandom_range(0, 3) != 0);
         dd  = 1'($urandom_range(0, 1));
         tog = 1'($urandom_range(0, 1));
         drive(p, c, dd, tog ? TOG : NONE, 5);
         if (!c)      m_s = 1'b0;
         else if (!p) m_s = 1'b1;
         if (tog && clk && p && c) m_s = dd;
         mo = model_out(p, c, m_s);
         check("random", mo[1], mo[0]);
      end

      // Clear asserted in the same instant as a rising edge: clear wins.
      clk = 1'b0; pre = 1'b1; clr = 1'b1; d = 1'b1;
      #5 clk = 1'b1;
      #2 check("seq_capture_before_clr", 1, 0);
      #3 clk = 1'b0;
      #5;
      clr = 1'b0;
      clk = 1'b1;
      #2 check("seq_clr_on_edge", 0, 1);
      clr = 1'b1;
      #5 check("seq_clr_release_no_edge", 0, 1);

      // Preset asserted in the same instant as a rising edge with d=0.
      clk = 1'b0;
      #5;
      d   = 1'b0;
      pre = 1'b0;
      clk = 1'b1;
      #2 check("seq_pre_on_edge", 1, 0);
      pre = 1'b1;
      #5 check("seq_pre_release_no_edge", 1, 0);
      clk = 1'b0;
      #5 clk = 1'b1;
      #2 check("seq_capture_after_pre", 0, 1);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
